// File: rtl/gmii_udp_av_rx.sv
// GMII receiver for the HDMI-over-Ethernet sink: filters IPv4/UDP frames addressed
// to this node and splits the payload into video pixel words and 12-bit AUX words.
`timescale 1ns/1ps
module gmii_udp_av_rx #(
  parameter logic [31:0] IPV4_DST_BASE = 32'hC0A80001,
  parameter logic [15:0] DST_PORT      = 16'd12345,
  parameter int          ID_W          = 1,
  parameter int          PIX_BYTES     = 2,
  parameter int          VID_PIXELS    = 640,
  parameter int          AUX_WORDS     = 32,
  parameter logic [7:0]  TYPE_VIDEO    = 8'h00,
  parameter logic [7:0]  TYPE_AUDIO    = 8'h01
) (
  input  logic                      clk125,
  input  logic                      sys_rst,
  input  logic [ID_W-1:0]           id,
  input  logic [7:0]                rxd,
  input  logic                      rx_dv,
  output logic [12+8*PIX_BYTES:0]   vid_data,
  output logic                      vid_wr_en,
  input  logic                      vid_full,
  output logic [11:0]               aux_data,
  output logic                      aux_wr_en,
  input  logic                      aux_full,
  output logic                      packet_en,
  output logic [15:0]               drop_cnt,
  output logic [15:0]               trunc_cnt
);
  localparam int PIX_W = 8 * PIX_BYTES;
  localparam int PB_W  = $clog2(PIX_BYTES + 1);
  localparam int PC_W  = $clog2(VID_PIXELS + 1);
  localparam int AC_W  = $clog2(AUX_WORDS + 1);

  typedef enum logic [2:0] {HDR, VID_HDR, VID_PAY, AUX_HDR, AUX_PAY, DISCARD} state_t;

  typedef struct packed {
    logic [15:0] etype;
    logic [7:0]  ver_ihl;
    logic [7:0]  proto;
    logic [31:0] dst_ip;
    logic [15:0] dst_port;
  } hdr_t;

  state_t            state, state_d;
  hdr_t              hdr;
  logic [10:0]       bc;
  logic [10:0]       line;
  logic              x0;
  logic [PIX_W-1:0]  pix_buf, pix_next;
  logic [PB_W-1:0]   pb_cnt;
  logic [PC_W-1:0]   pix_cnt;
  logic [7:0]        aux_lo;
  logic [3:0]        aux_hi4;
  logic [1:0]        aux_ph;
  logic [AC_W-1:0]   aux_cnt;
  logic [11:0]       aux_word_d;
  logic              vid_we_d, aux_we_d, pen_d, drop_inc, trunc_inc;
  logic              pix_last, hdr_match;
  logic [7:0]        ip_lo;

  assign ip_lo     = IPV4_DST_BASE[7:0] + 8'(id);
  assign hdr_match = (hdr.etype == 16'h0800) && (hdr.ver_ihl == 8'h45) &&
                     (hdr.proto == 8'h11) &&
                     (hdr.dst_ip[31:8] == IPV4_DST_BASE[31:8]) &&
                     (hdr.dst_ip[7:0] == ip_lo) && (hdr.dst_port == DST_PORT);
  assign pix_last  = (pb_cnt == PB_W'(PIX_BYTES - 1));

  always_comb begin
    state_d    = state;
    pen_d      = packet_en;
    vid_we_d   = 1'b0;
    aux_we_d   = 1'b0;
    drop_inc   = 1'b0;
    trunc_inc  = 1'b0;
    aux_word_d = '0;
    // first pixel byte ends up in the MSBs after PIX_BYTES shifts
    pix_next   = PIX_W'({pix_buf, rxd});
    if (!rx_dv) begin
      // frame end wins over any simultaneous FIFO-full condition
      state_d = HDR;
      pen_d   = 1'b0;
      if (state inside {VID_HDR, VID_PAY, AUX_HDR, AUX_PAY}) trunc_inc = 1'b1;
    end else begin
      case (state)
        HDR: if (bc == 11'h32) begin
          if (hdr_match && rxd == TYPE_VIDEO)      state_d = VID_HDR;
          else if (hdr_match && rxd == TYPE_AUDIO) state_d = AUX_HDR;
          else                                     state_d = DISCARD;
        end
        VID_HDR: if (bc == 11'h34) begin
          state_d = VID_PAY;
          pen_d   = 1'b1;
        end
        VID_PAY: if (pix_last) begin
          if (vid_full) begin
            state_d  = DISCARD;
            pen_d    = 1'b0;
            drop_inc = 1'b1;
          end else begin
            vid_we_d = 1'b1;
            if (pix_cnt == PC_W'(VID_PIXELS - 1)) begin
              state_d = DISCARD;
              pen_d   = 1'b0;
            end
          end
        end
        AUX_HDR: if (bc == 11'h34) begin
          aux_word_d = {rxd[3:0], aux_lo};
          if (aux_full) begin
            state_d  = DISCARD;
            drop_inc = 1'b1;
          end else begin
            aux_we_d = 1'b1;
            state_d  = AUX_PAY;
          end
        end
        AUX_PAY: if (aux_ph != 2'd0) begin
          aux_word_d = (aux_ph == 2'd1) ? {rxd[3:0], aux_lo} : {rxd, aux_hi4};
          if (aux_full) begin
            state_d  = DISCARD;
            drop_inc = 1'b1;
          end else begin
            aux_we_d = 1'b1;
            if (aux_cnt == AC_W'(AUX_WORDS - 1)) state_d = DISCARD;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk125 or posedge sys_rst) begin
    if (sys_rst) state <= HDR;
    else         state <= state_d;
  end

  always_ff @(posedge clk125 or posedge sys_rst) begin
    if (sys_rst) begin
      vid_data  <= '0;
      vid_wr_en <= 1'b0;
      aux_data  <= '0;
      aux_wr_en <= 1'b0;
      packet_en <= 1'b0;
      drop_cnt  <= '0;
      trunc_cnt <= '0;
      bc        <= '0;
      hdr       <= '0;
      line      <= '0;
      x0        <= 1'b0;
      pix_buf   <= '0;
      pb_cnt    <= '0;
      pix_cnt   <= '0;
      aux_lo    <= '0;
      aux_hi4   <= '0;
      aux_ph    <= '0;
      aux_cnt   <= '0;
    end else begin
      packet_en <= pen_d;
      vid_wr_en <= vid_we_d;
      aux_wr_en <= aux_we_d;
      if (vid_we_d) vid_data <= {1'b0, x0, line, pix_next};
      if (aux_we_d) aux_data <= aux_word_d;
      if (drop_inc && drop_cnt != 16'hFFFF)   drop_cnt  <= drop_cnt + 16'd1;
      if (trunc_inc && trunc_cnt != 16'hFFFF) trunc_cnt <= trunc_cnt + 16'd1;
      if (!rx_dv) begin
        bc      <= '0;
        hdr     <= '0;
        line    <= '0;
        x0      <= 1'b0;
        pb_cnt  <= '0;
        pix_cnt <= '0;
        aux_ph  <= '0;
        aux_cnt <= '0;
      end else begin
        if (bc != 11'h7FF) bc <= bc + 11'd1;
        case (state)
          HDR: case (bc)
            11'h14: hdr.etype[15:8]    <= rxd;
            11'h15: hdr.etype[7:0]     <= rxd;
            11'h16: hdr.ver_ihl        <= rxd;
            11'h1F: hdr.proto          <= rxd;
            11'h26: hdr.dst_ip[31:24]  <= rxd;
            11'h27: hdr.dst_ip[23:16]  <= rxd;
            11'h28: hdr.dst_ip[15:8]   <= rxd;
            11'h29: hdr.dst_ip[7:0]    <= rxd;
            11'h2C: hdr.dst_port[15:8] <= rxd;
            11'h2D: hdr.dst_port[7:0]  <= rxd;
            default: ;
          endcase
          VID_HDR: begin
            if (bc == 11'h33) line[7:0] <= rxd;
            if (bc == 11'h34) begin
              line[10:8] <= rxd[2:0];
              x0         <= rxd[4];
              pb_cnt     <= '0;
              pix_cnt    <= '0;
            end
          end
          VID_PAY: begin
            pix_buf <= pix_next;
            pb_cnt  <= pix_last ? '0 : pb_cnt + 1'b1;
            if (pix_last) pix_cnt <= pix_cnt + 1'b1;
          end
          AUX_HDR: begin
            if (bc == 11'h33) aux_lo <= rxd;
            if (bc == 11'h34) begin
              aux_ph  <= '0;
              aux_cnt <= '0;
            end
          end
          AUX_PAY: begin
            // byte triple p0,p1,p2 carries two 12-bit samples
            aux_ph <= (aux_ph == 2'd2) ? 2'd0 : aux_ph + 2'd1;
            if (aux_ph == 2'd0) aux_lo  <= rxd;
            if (aux_ph == 2'd1) aux_hi4 <= rxd[7:4];
            if (aux_we_d) aux_cnt <= aux_cnt + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule
